lcd_bus_rx: RTL
===============

// Module: lcd_bus_rx
// PURPOSE
//  Receive-side model of the HD44780-style 8-bit parallel LCD bus driven by the game's LCD controller.
//  Decodes E/RS/RW/DATA strobes into a 2x16 character shadow RAM, cursor address and display state.
//  Shadow is readable by index for on-board mirroring (VGA/7-seg) and for self-checking benches.
// PARAMETERS
//  MIN_E_HIGH   20    min consecutive synced cycles E must be high for a strobe to count
//  CLEAR_CYC    32    busy cycles consumed by Clear Display (one shadow cell cleared per cycle)
// PORTS
//  clk           in   1   system clock (50 MHz)
//  rst_n         in   1   asynchronous reset, active-low
//  i_lcd_e       in   1   LCD enable strobe
//  i_lcd_rs      in   1   0 = command, 1 = data
//  i_lcd_rw      in   1   0 = write, 1 = read
//  i_lcd_data    in   8   LCD data bus
//  i_rd_idx      in   5   shadow read index: 0-15 row0, 16-31 row1
//  o_rd_char     out  8   shadow[i_rd_idx], registered, 1-cycle latency
//  o_ac          out  7   address counter (DDRAM address)
//  o_disp_on     out  1   display-on bit from last Display Control command
//  o_busy        out  1   high while Clear walker runs
//  o_cmd_valid   out  1   1-cycle pulse: command byte accepted; byte on o_byte
//  o_data_valid  out  1   1-cycle pulse: data byte accepted; byte on o_byte
//  o_byte        out  8   last accepted byte
//  o_frame_done  out  1   1-cycle pulse: data write landed on shadow index 31
//  o_overrun     out  1   1-cycle pulse: strobe arrived while busy, dropped
//  o_glitch      out  1   1-cycle pulse: E high for fewer than MIN_E_HIGH cycles, dropped
// BEHAVIOUR
//  - Reset: shadow all 0x20; o_ac=0; I/D=1; o_disp_on=0; o_busy=0; all pulses 0; o_rd_char=0x20; o_byte=0.
//  - Input path: E, RS, RW, DATA through 2-flop synchronizer. e_cnt counts synced-E high cycles, saturating.
//  - Strobe: synced-E falling edge. RS/RW/DATA taken from the sample of the last E-high cycle.
//    Accept if e_cnt>=MIN_E_HIGH, else o_glitch. RW=1 strobes are ignored silently.
//  - Accepted strobe while o_busy=1: dropped, o_overrun pulse, no state change.
//  - Decode, accept-cycle+1, highest set bit wins:
//    1xxxxxxx Set DDRAM: o_ac<=data[6:0]
//    01xxxxxx Set CGRAM: ignored, o_cmd_valid only
//    001xxxxx Function Set: ignored, o_cmd_valid only
//    0001xxxx Shift: ignored, o_cmd_valid only
//    00001DCB Display Control: o_disp_on<=D
//    000001IS Entry Mode: I/D<=I; S ignored
//    0000001x Return Home: o_ac<=0
//    00000001 Clear: o_ac<=0, I/D<=1, o_busy=1 for CLEAR_CYC cycles, walker writes 0x20 to idx 0..31
//    00000000 no-op: o_cmd_valid only
//  - Data write: when o_ac is 0x00-0x0F -> idx=o_ac; 0x40-0x4F -> idx=16+o_ac[3:0]; else not stored.
//    o_ac then steps by I/D. o_data_valid always pulses; o_frame_done only when stored idx==31.
//  - AC wrap, 2-line map: +1 0x27->0x40, 0x67->0x00; -1 0x00->0x67, 0x40->0x27.
//    Addresses 0x28-0x3F and 0x68-0x7F are reachable only via Set DDRAM; +1 from them is plain increment mod 128.
//  - Read port: o_rd_char updates every cycle from i_rd_idx. Same-cycle write to the read idx returns the old value.
//  - Reset asserted mid-Clear or mid-strobe: immediate return to reset state; partial E pulse is discarded.
// STRUCTURE
//  - Package lcd_pkg: HD44780 command-prefix masks, DDRAM row bases (0x00/0x40), ROW_LEN=16, line-end 0x27/0x67, SPACE=0x20.
//  - Package lcd_pkg is shared with the LCD controller.
//  - Sub-module lcd_strobe_sync: synchronizer, E-width counter, falling-edge detect.
//    It outputs strobe_ok/strobe_glitch plus captured rs/rw/data.
//  - Top: decode FSM with states IDLE, CLEAR; AC logic; 32x8 shadow.
// TESTING
//  1. Bytes 38,0C,06,01,80 (RS=0, E high 50 cycles) -> 5 cmd pulses; o_busy high 32 cycles after 01; o_disp_on=1; o_ac=0.
//  2. RS=1 data 0x50 -> rd idx0=0x50; o_ac=0x01; o_data_valid with o_byte=0x50.
//  3. Cmd C0, then 16 data 'A'..'P' -> idx16..31='A'..'P'; o_frame_done on 16th; o_ac=0x50.
//  4. Cmd 04 (I/D=0), Set 0x40, data 'Z' -> idx16='Z'; o_ac=0x27. Cmd 06, Set 0x27, data 'Q' -> o_ac=0x40, idx16 unchanged.
//  5. E pulse 5 cycles wide -> o_glitch, no state change. Data strobe 10 cycles after 01 -> o_overrun, shadow stays 0x20.
//  6. rst_n low mid-Clear (walker at idx 12) -> all outputs at reset values; all 32 idx read 0x20.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared HD44780 bus definitions: command prefixes, DDRAM row layout and
// address-counter helpers used by both the LCD controller and the receiver.
package lcd_pkg;

   // Command prefixes: the highest set bit of a command byte selects it
   localparam logic [7:0] MASK_SET_DDRAM  = 8'h80;
   localparam logic [7:0] MASK_SET_CGRAM  = 8'h40;
   localparam logic [7:0] MASK_FUNC_SET   = 8'h20;
   localparam logic [7:0] MASK_SHIFT      = 8'h10;
   localparam logic [7:0] MASK_DISP_CTRL  = 8'h08;
   localparam logic [7:0] MASK_ENTRY_MODE = 8'h04;
   localparam logic [7:0] MASK_HOME       = 8'h02;
   localparam logic [7:0] MASK_CLEAR      = 8'h01;

   // 2-line DDRAM map
   localparam logic [6:0] ROW0_BASE = 7'h00;
   localparam logic [6:0] ROW1_BASE = 7'h40;
   localparam logic [6:0] ROW0_END  = 7'h27;
   localparam logic [6:0] ROW1_END  = 7'h67;
   localparam int         ROW_LEN   = 16;
   localparam logic [7:0] SPACE     = 8'h20;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } rx_state_t;

   typedef enum logic [3:0] {
      CMD_NOP,
      CMD_CLEAR,
      CMD_HOME,
      CMD_ENTRY,
      CMD_DISP,
      CMD_SHIFT,
      CMD_FUNC,
      CMD_CGRAM,
      CMD_DDRAM
   } cmd_t;

   // Highest set bit wins
   function automatic cmd_t decode_cmd(input logic [7:0] b);
      cmd_t c;
      if      ((b & MASK_SET_DDRAM)  != 8'h00) c = CMD_DDRAM;
      else if ((b & MASK_SET_CGRAM)  != 8'h00) c = CMD_CGRAM;
      else if ((b & MASK_FUNC_SET)   != 8'h00) c = CMD_FUNC;
      else if ((b & MASK_SHIFT)      != 8'h00) c = CMD_SHIFT;
      else if ((b & MASK_DISP_CTRL)  != 8'h00) c = CMD_DISP;
      else if ((b & MASK_ENTRY_MODE) != 8'h00) c = CMD_ENTRY;
      else if ((b & MASK_HOME)       != 8'h00) c = CMD_HOME;
      else if ((b & MASK_CLEAR)      != 8'h00) c = CMD_CLEAR;
      else                                     c = CMD_NOP;
      return c;
   endfunction

   // Address counter step with line wrap; off-map addresses step plainly mod 128
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] n;
      if (inc) begin
         if      (ac == ROW0_END) n = ROW1_BASE;
         else if (ac == ROW1_END) n = ROW0_BASE;
         else                     n = ac + 7'd1;
      end else begin
         if      (ac == ROW0_BASE) n = ROW1_END;
         else if (ac == ROW1_BASE) n = ROW0_END;
         else                      n = ac - 7'd1;
      end
      return n;
   endfunction

   // Map a DDRAM address to a shadow index; bit 5 of the result is the hit flag
   function automatic logic [5:0] ac_to_idx(input logic [6:0] ac);
      logic [5:0] r;
      r = 6'd0;
      if (ac >= ROW0_BASE && ac < ROW0_BASE + 7'(ROW_LEN))
         r = {1'b1, 1'b0, ac[3:0]};
      else if (ac >= ROW1_BASE && ac < ROW1_BASE + 7'(ROW_LEN))
         r = {1'b1, 1'b1, ac[3:0]};
      return r;
   endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Bus synchronizer: brings E/RS/RW/DATA into the clk domain, measures the
// width of each E-high pulse and flags its falling edge as good or glitch.
module lcd_strobe_sync #(
   parameter int MIN_E_HIGH = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   output logic       strobe_ok,
   output logic       strobe_glitch,
   output logic       cap_rs,
   output logic       cap_rw,
   output logic [7:0] cap_data
);

   localparam int CW = $clog2(MIN_E_HIGH + 1);

   logic [10:0]   sync1;
   logic [10:0]   sync2;
   logic          e_s;
   logic          e_q;
   logic [CW-1:0] e_cnt;
   logic          fall;
   logic          wide_enough;

   assign e_s = sync2[10];

   // Two-flop synchronizer for the whole bus, sampled as one word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
         sync2 <= sync1;
      end
   end

   // E history, saturating high-width count and capture of the last E-high sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q      <= 1'b0;
         e_cnt    <= '0;
         cap_rs   <= 1'b0;
         cap_rw   <= 1'b0;
         cap_data <= 8'h00;
      end else begin
         e_q <= e_s;
         if (!e_s)
            e_cnt <= '0;
         else if (e_cnt != CW'(MIN_E_HIGH))
            e_cnt <= e_cnt + CW'(1);
         if (e_s) begin
            cap_rs   <= sync2[9];
            cap_rw   <= sync2[8];
            cap_data <= sync2[7:0];
         end
      end
   end

   // On the falling-edge cycle e_cnt still holds the length of the pulse that just ended
   always_comb begin
      fall          = e_q & ~e_s;
      wide_enough   = (e_cnt == CW'(MIN_E_HIGH));
      strobe_ok     = fall & wide_enough;
      strobe_glitch = fall & ~wide_enough;
   end

endmodule

// File: rtl/lcd_bus_rx.sv
// HD44780 bus receiver: decodes accepted write strobes into a 2x16 shadow RAM,
// the DDRAM address counter and display-on state; Clear runs a one-cell-per-cycle walker.
//
// Output pulses (o_cmd_valid, o_data_valid, o_frame_done, o_overrun, o_glitch) are
// single-cycle, appear one cycle after the strobe is accepted, and have no ready:
// the consumer must sample them on the cycle they are high. o_byte holds the last
// accepted byte and is valid together with o_cmd_valid/o_data_valid and afterwards.
module lcd_bus_rx
   import lcd_pkg::*;
#(
   parameter int MIN_E_HIGH = 20,
   parameter int CLEAR_CYC  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_lcd_e,
   input  logic       i_lcd_rs,
   input  logic       i_lcd_rw,
   input  logic [7:0] i_lcd_data,
   input  logic [4:0] i_rd_idx,
   output logic [7:0] o_rd_char,
   output logic [6:0] o_ac,
   output logic       o_disp_on,
   output logic       o_busy,
   output logic       o_cmd_valid,
   output logic       o_data_valid,
   output logic [7:0] o_byte,
   output logic       o_frame_done,
   output logic       o_overrun,
   output logic       o_glitch
);

   logic       strobe_ok;
   logic       strobe_glitch;
   logic       cap_rs;
   logic       cap_rw;
   logic [7:0] cap_data;

   rx_state_t  state;
   rx_state_t  state_next;
   logic [5:0] clr_cnt;
   logic       inc_dec;
   logic       accept;
   logic       idle_accept;
   logic [5:0] wr_map;
   cmd_t       cmd;
   logic [7:0] shadow [32];

   lcd_strobe_sync #(.MIN_E_HIGH(MIN_E_HIGH)) u_sync (
      .clk           (clk),
      .rst_n         (rst_n),
      .lcd_e         (i_lcd_e),
      .lcd_rs        (i_lcd_rs),
      .lcd_rw        (i_lcd_rw),
      .lcd_data      (i_lcd_data),
      .strobe_ok     (strobe_ok),
      .strobe_glitch (strobe_glitch),
      .cap_rs        (cap_rs),
      .cap_rw        (cap_rw),
      .cap_data      (cap_data)
   );

   // Reads from the bus are not modelled; only good write strobes are accepted
   assign accept      = strobe_ok & ~cap_rw;
   assign idle_accept = accept & (state == ST_IDLE);
   assign wr_map      = ac_to_idx(o_ac);
   assign cmd         = decode_cmd(cap_data);
   assign o_busy      = (state == ST_CLEAR);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state: enter CLEAR on an accepted Clear command, leave when the walker ends
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (idle_accept && !cap_rs && cmd == CMD_CLEAR) state_next = ST_CLEAR;
         ST_CLEAR: if (clr_cnt == 6'(CLEAR_CYC - 1))              state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Command/data decode, address counter, display state and event pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_ac         <= 7'h00;
         inc_dec      <= 1'b1;
         o_disp_on    <= 1'b0;
         o_byte       <= 8'h00;
         o_cmd_valid  <= 1'b0;
         o_data_valid <= 1'b0;
         o_frame_done <= 1'b0;
         o_overrun    <= 1'b0;
         o_glitch     <= 1'b0;
         clr_cnt      <= 6'd0;
      end else begin
         o_cmd_valid  <= 1'b0;
         o_data_valid <= 1'b0;
         o_frame_done <= 1'b0;
         o_overrun    <= accept & (state == ST_CLEAR);
         o_glitch     <= strobe_glitch;
         if (state == ST_CLEAR)
            clr_cnt <= clr_cnt + 6'd1;
         if (idle_accept) begin
            o_byte <= cap_data;
            if (cap_rs) begin
               o_data_valid <= 1'b1;
               o_frame_done <= wr_map[5] & (wr_map[4:0] == 5'd31);
               o_ac         <= ac_step(o_ac, inc_dec);
            end else begin
               o_cmd_valid <= 1'b1;
               case (cmd)
                  CMD_DDRAM: o_ac      <= cap_data[6:0];
                  CMD_DISP:  o_disp_on <= cap_data[2];
                  CMD_ENTRY: inc_dec   <= cap_data[1];
                  CMD_HOME:  o_ac      <= 7'h00;
                  CMD_CLEAR: begin
                     o_ac    <= 7'h00;
                     inc_dec <= 1'b1;
                     clr_cnt <= 6'd0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Shadow RAM: the Clear walker and data writes never overlap (data only lands in IDLE)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) shadow[i] <= SPACE;
      end else if (state == ST_CLEAR) begin
         if (clr_cnt < 6'd32) shadow[clr_cnt[4:0]] <= SPACE;
      end else if (idle_accept && cap_rs && wr_map[5]) begin
         shadow[wr_map[4:0]] <= cap_data;
      end
   end

   // Registered read port; a write in the same cycle shows up one read later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) o_rd_char <= SPACE;
      else        o_rd_char <= shadow[i_rd_idx];
   end

endmodule
